param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
- Parametrised successor to the team's 3-bit T-flip-flop Mealy sequence detector.
- Scans a serial bit stream `x` for two programmable LEN-bit patterns and reports hits on a 2-bit Mealy `output_code`.
- Adds a qualifying strobe, runtime overlap/non-overlap mode, and optional hit counters.
- Sits between a serial front end and the lab control logic.

Parameters:
- LEN, 4, pattern length in bits (2..16).
- PAT0, 4'b1011, pattern reported on output_code[0]; the first-received bit is the MSB.
- PAT1, 4'b0110, pattern reported on output_code[1]; the first-received bit is the MSB.
- CNT_W, 8, width of each hit counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- x_valid  input  1  qualifies x; history advances only when high.
- x  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on every valid cycle.
- output_code  output  2  Mealy hit flags: bit0 = PAT0, bit1 = PAT1.
- fill  output  clog2(LEN)+1  number of valid history bits, saturating at LEN-1.
- hit0_cnt  output  CNT_W  PAT0 hit count (optional feature).
- hit1_cnt  output  CNT_W  PAT1 hit count (optional feature).

Behaviour:
- Reset (reset==0 at a rising edge):
  - hist, fill and both counters clear to 0.
  - A reset mid-pattern discards all partial history.
  - output_code reads 0 while reset is low, regardless of x/x_valid.
- State:
  - hist[LEN-2:0] holds the last LEN-1 accepted bits; the most recent is at bit 0.
  - fill is 0..LEN-1.
- Window: w = {hist[LEN-2:0], x}.
- Mealy outputs, combinational and zero-latency:
  - output_code[0] = x_valid & (fill==LEN-1) & (w==PAT0).
  - output_code[1] = x_valid & (fill==LEN-1) & (w==PAT1).
- Idle cycles (x_valid==0):
  - State holds.
  - output_code = 2'b00.
- Valid cycle with no hit:
  - hist <= {hist[LEN-3:0], x}.
  - fill <= min(fill+1, LEN-1).
- Valid cycle with any hit (either output_code bit set):
  - If overlap_en==1: shift as normal, so the window slides by one and overlapping hits are reported.
  - If overlap_en==0: fill <= 0. hist contents are don't-care. The next hit needs LEN fresh valid bits.
- Simultaneous hits:
  - If PAT0==PAT1, both bits assert together (2'b11).
  - In non-overlap mode the history clears once, and both counters increment.
- A change of overlap_en takes effect on the first valid cycle at which it is sampled. Past history is never cleared retroactively.
- Counters (optional feature):
  - Increment on the rising edge of each cycle in which the corresponding output_code bit is 1.
  - Saturate at 2^CNT_W-1; there is no wrap.
- Implementation freedom: history may be built from T- or D-flops. The externally visible timing above is mandatory.

Optional Feature:
- Macro: SEQ_DET_HIT_CNT_EN.
- Defined: hit0_cnt and hit1_cnt are live saturating registers with the behaviour above. Reset clears them to 0.
- Undefined: no counter flops are synthesised, and hit0_cnt/hit1_cnt are tied to 0. The port list is unchanged.

Test Plan:
- Overlap detection. Reset low 2 cycles then high; overlap_en=1; feed x=1,0,1,1,0,1,1 with x_valid=1.
  - output_code=2'b01 on bits 4 and 7; 2'b10 on bit 5; 00 otherwise.
  - With SEQ_DET_HIT_CNT_EN: hit0_cnt=2 and hit1_cnt=1 afterwards.
- Non-overlap detection. Same stream, overlap_en=0.
  - output_code=2'b01 on bit 4 only.
  - fill reads 0 after bit 4 and 3 after bit 7.
- Gaps in x_valid. Stream 1,0,1,1 with x_valid low for 3 cycles between each bit (x toggling randomly while low).
  - Exactly one 2'b01 pulse, coinciding with the 4th valid bit.
  - output_code=0 on every idle cycle.
- Reset mid-pattern. Feed 1,0,1, pulse reset low for 1 cycle, then feed 1.
  - No hit.
  - fill=1 after the final bit.
- Counter saturation (SEQ_DET_HIT_CNT_EN, CNT_W=2). Feed 1011 repeatedly in non-overlap mode, 5 times.
  - hit0_cnt reads 1,2,3,3,3.
  - output_code[0] still pulses on all 5 hits.
- Identical patterns and feature-off build.
  - PAT0=PAT1=4'b1111, feed 1,1,1,1: output_code=2'b11 on bit 4.
  - Build without SEQ_DET_HIT_CNT_EN: hit0_cnt=hit1_cnt=0 throughout.

Source files
------------

// File: rtl/param_seq_detector.sv
// Serial detector for two programmable LEN-bit patterns; Mealy hit flags, optional saturating hit counters (SEQ_DET_HIT_CNT_EN).
// Latency: output_code is combinational in the same cycle as the completing bit; history/fill/counters update on the next edge.
// Backpressure: none; x_valid only qualifies input bits, idle cycles hold all state.
module param_seq_detector #(
    parameter int unsigned     LEN    = 4,
    parameter logic [LEN-1:0]  PAT0   = 4'b1011,
    parameter logic [LEN-1:0]  PAT1   = 4'b0110,
    parameter int unsigned     CNT_W  = 8,
    localparam int unsigned    FILL_W = $clog2(LEN) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic              x,
    input  logic              overlap_en,
    output logic [1:0]        output_code,
    output logic [FILL_W-1:0] fill,
    output logic [CNT_W-1:0]  hit0_cnt,
    output logic [CNT_W-1:0]  hit1_cnt
);

    logic [LEN-2:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [LEN-1:0]    win;
    logic              full;
    logic              hit0, hit1;

    always_comb begin
        win    = {hist_q, x};
        full   = (fill_q == FILL_W'(LEN - 1));
        // Gating with reset keeps the flags quiet while the synchronous reset is pending.
        hit0   = reset & x_valid & full & (win == PAT0);
        hit1   = reset & x_valid & full & (win == PAT1);
        hist_d = hist_q;
        fill_d = fill_q;
        if (x_valid) begin
            hist_d = win[LEN-2:0];
            if ((hit0 | hit1) && !overlap_en) begin
                fill_d = '0;
            end else if (!full) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign output_code = {hit1, hit0};
    assign fill        = fill_q;

`ifdef SEQ_DET_HIT_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (hit0 && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (hit1 && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign hit0_cnt = cnt0_q;
    assign hit1_cnt = cnt1_q;
`else
    assign hit0_cnt = '0;
    assign hit1_cnt = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: expected Mealy codes queued at drive time, popped and asserted at sample time.
module tb_param_seq_detector;

`ifdef SEQ_DET_HIT_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic x_valid;
    logic x;
    logic overlap_en;

    logic [1:0] oc_main, oc_sat, oc_same;
    logic [2:0] fill_main, fill_sat, fill_same;
    logic [7:0] c0_main, c1_main, c0_same, c1_same;
    logic [1:0] c0_sat, c1_sat;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    param_seq_detector #(.LEN(4), .PAT0(4'b1011), .PAT1(4'b0110), .CNT_W(8)) dut_main (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap_en(overlap_en),
        .output_code(oc_main), .fill(fill_main), .hit0_cnt(c0_main), .hit1_cnt(c1_main));

    param_seq_detector #(.LEN(4), .PAT0(4'b1011), .PAT1(4'b0110), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap_en(overlap_en),
        .output_code(oc_sat), .fill(fill_sat), .hit0_cnt(c0_sat), .hit1_cnt(c1_sat));

    param_seq_detector #(.LEN(4), .PAT0(4'b1111), .PAT1(4'b1111), .CNT_W(8)) dut_same (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap_en(overlap_en),
        .output_code(oc_same), .fill(fill_same), .hit0_cnt(c0_same), .hit1_cnt(c1_same));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] pick(input int sel);
        case (sel)
            1:       return oc_sat;
            2:       return oc_same;
            default: return oc_main;
        endcase
    endfunction

    // Drive one cycle, queue the expected Mealy code, sample it mid-cycle, then step past the edge.
    task automatic step(input int sel, input logic v, input logic b, input logic [1:0] expc, input string tag);
        @(negedge clk);
        x_valid = v;
        x       = b;
        exp_q.push_back(expc);
        #1;
        chk(tag, 32'(pick(sel)), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset   = 1'b0;
            x_valid = 1'b1;
            x       = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_oc_in_reset"}, 32'(oc_main), 32'(0));
        end
        @(negedge clk);
        reset   = 1'b1;
        x_valid = 1'b0;
        #1;
        chk({tag, "_fill_after_reset"}, 32'(fill_main), 32'(0));
    endtask

    logic [6:0] stream;
    logic [1:0] exp_ov [7];
    logic [1:0] exp_no [7];

    initial begin
        reset      = 1'b1;
        x_valid    = 1'b0;
        x          = 1'b0;
        overlap_en = 1'b1;
        stream     = 7'b1011011;
        exp_ov     = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        exp_no     = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};

        // Overlapping detection
        do_reset(2, "ovl");
        chk("rst_cnt0", 32'(c0_main), 32'(0));
        chk("rst_cnt1", 32'(c1_main), 32'(0));
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b1, stream[6-i], exp_ov[i], $sformatf("ovl_bit%0d", i + 1));
        end
        chk("ovl_cnt0", 32'(c0_main), 32'(CNT_ON * 2));
        chk("ovl_cnt1", 32'(c1_main), 32'(CNT_ON * 1));

        // Non-overlapping detection
        overlap_en = 1'b0;
        do_reset(1, "nov");
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b1, stream[6-i], exp_no[i], $sformatf("nov_bit%0d", i + 1));
            if (i == 3) chk("nov_fill_bit4", 32'(fill_main), 32'(0));
        end
        chk("nov_fill_bit7", 32'(fill_main), 32'(3));
        chk("nov_cnt0", 32'(c0_main), 32'(CNT_ON));

        // Gaps in x_valid with random x while idle
        overlap_en = 1'b1;
        do_reset(1, "gap");
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, stream[6-i], (i == 3) ? 2'b01 : 2'b00, $sformatf("gap_bit%0d", i + 1));
            if (i < 3) begin
                for (int j = 0; j < 3; j++) begin
                    step(0, 1'b0, 1'($urandom_range(0, 1)), 2'b00, "gap_idle");
                end
            end
        end
        chk("gap_fill_hold", 32'(fill_main), 32'(3));

        // Reset mid-pattern discards partial history
        do_reset(1, "mid");
        step(0, 1'b1, 1'b1, 2'b00, "mid_b1");
        step(0, 1'b1, 1'b0, 2'b00, "mid_b2");
        step(0, 1'b1, 1'b1, 2'b00, "mid_b3");
        chk("mid_fill_pre", 32'(fill_main), 32'(3));
        do_reset(1, "mid_pulse");
        step(0, 1'b1, 1'b1, 2'b00, "mid_b4");
        chk("mid_fill_post", 32'(fill_main), 32'(1));

        // Counter saturation on the CNT_W=2 instance
        overlap_en = 1'b0;
        do_reset(1, "sat");
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                step(1, 1'b1, stream[6-i], (i == 3) ? 2'b01 : 2'b00, $sformatf("sat_rep%0d_bit%0d", k + 1, i + 1));
            end
            chk($sformatf("sat_cnt0_rep%0d", k + 1), 32'(c0_sat), 32'(CNT_ON * ((k < 3) ? k + 1 : 3)));
        end
        chk("sat_cnt1", 32'(c1_sat), 32'(0));

        // Identical patterns assert both bits together
        do_reset(1, "same");
        for (int i = 0; i < 4; i++) begin
            step(2, 1'b1, 1'b1, (i == 3) ? 2'b11 : 2'b00, $sformatf("same_bit%0d", i + 1));
        end
        chk("same_fill", 32'(fill_same), 32'(0));
        chk("same_cnt0", 32'(c0_same), 32'(CNT_ON));
        chk("same_cnt1", 32'(c1_same), 32'(CNT_ON));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
